// File: rtl/result_unloader_if.sv
// Byte stream from the result unloader to its downstream consumer.
// The producer (master) holds data_out/ctrl_out while out_valid is high and out_ready is low.
interface result_unloader_if;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       out_valid;
  logic       out_ready;

  modport master (output data_out, output ctrl_out, output out_valid, input out_ready);
  modport slave  (input data_out, input ctrl_out, input out_valid, output out_ready);
endinterface

// File: rtl/result_unloader.sv
// Serialises a result matrix as a framed byte stream: rows/cols header, element bytes
// (MSB first), optional XOR checksum (UNLOADER_CHECKSUM_EN), end-of-frame marker.
//
// state  | meaning
// IDLE   | waiting for res_valid, snapshot taken on the sampling edge
// HDR_R  | presenting row count header byte
// HDR_C  | presenting column count header byte
// DATA   | presenting element bytes, index order, MSB byte first
// CSUM   | presenting XOR of header and data bytes (only with UNLOADER_CHECKSUM_EN)
// END    | presenting end-of-frame marker
module result_unloader #(
  parameter int ELEM_W    = 16,
  parameter int MAX_ELEMS = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [MAX_ELEMS*ELEM_W-1:0]   res_mat,
  input  logic [3:0]                    rows,
  input  logic [3:0]                    cols,
  input  logic                          res_valid,
  output logic                          busy,
  output logic                          clamp_err,
  result_unloader_if.master             stream
);

  localparam int MAT_W  = MAX_ELEMS * ELEM_W;
  localparam int NBYTES = MAT_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR_R = 3'd1,
    ST_HDR_C = 3'd2,
    ST_DATA  = 3'd3,
`ifdef UNLOADER_CHECKSUM_EN
    ST_CSUM  = 3'd4,
`endif
    ST_END   = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nx;
  state_t           after_data;
  logic [MAT_W-1:0] mat_q;
  logic [3:0]       rows_q;
  logic [3:0]       cols_q;
  logic [2:0]       n_q;
  logic [2:0]       idx;
  logic [7:0]       prod;
  logic             over;
  logic [2:0]       n_calc;
  logic [3:0]       two_n_m1;
  logic             last_byte;
  logic             accept;
  logic [7:0]       mat_bytes [NBYTES];
`ifdef UNLOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign prod      = {4'b0, rows} * {4'b0, cols};
  assign over      = prod > 8'(MAX_ELEMS);
  assign n_calc    = over ? 3'(MAX_ELEMS) : prod[2:0];
  assign two_n_m1  = {n_q, 1'b0} - 4'd1;
  assign last_byte = idx == two_n_m1[2:0];
  assign accept    = (state != ST_IDLE) && stream.out_ready;
  assign busy      = state != ST_IDLE;

  // Element 0 sits in the top bits, so byte 0 is the MSB byte of element 0.
  always_comb begin
    for (int i = 0; i < NBYTES; i++) begin
      mat_bytes[i] = mat_q[MAT_W-8-8*i +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    stream.data_out  = 8'h00;
    stream.ctrl_out  = 2'd0;
    stream.out_valid = 1'b0;
`ifdef UNLOADER_CHECKSUM_EN
    after_data = ST_CSUM;
`else
    after_data = ST_END;
`endif
    case (state)
      ST_IDLE: begin
        if (res_valid) state_nx = ST_HDR_R;
      end
      ST_HDR_R: begin
        stream.out_valid = 1'b1;
        stream.data_out  = {4'b0, rows_q};
        stream.ctrl_out  = 2'd1;
        if (accept) state_nx = ST_HDR_C;
      end
      ST_HDR_C: begin
        stream.out_valid = 1'b1;
        stream.data_out  = {4'b0, cols_q};
        stream.ctrl_out  = 2'd1;
        if (accept) state_nx = (n_q == 3'd0) ? after_data : ST_DATA;
      end
      ST_DATA: begin
        stream.out_valid = 1'b1;
        stream.data_out  = mat_bytes[idx];
        stream.ctrl_out  = 2'd0;
        if (accept && last_byte) state_nx = after_data;
      end
`ifdef UNLOADER_CHECKSUM_EN
      ST_CSUM: begin
        stream.out_valid = 1'b1;
        stream.data_out  = csum;
        stream.ctrl_out  = 2'd3;
        if (accept) state_nx = ST_END;
      end
`endif
      ST_END: begin
        stream.out_valid = 1'b1;
        stream.data_out  = 8'h00;
        stream.ctrl_out  = 2'd2;
        if (accept) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mat_q     <= '0;
      rows_q    <= 4'd0;
      cols_q    <= 4'd0;
      n_q       <= 3'd0;
      idx       <= 3'd0;
      clamp_err <= 1'b0;
`ifdef UNLOADER_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else if (state == ST_IDLE) begin
      if (res_valid) begin
        mat_q  <= res_mat;
        rows_q <= rows;
        cols_q <= cols;
        n_q    <= n_calc;
        idx    <= 3'd0;
`ifdef UNLOADER_CHECKSUM_EN
        csum   <= 8'h00;
`endif
        if (over) clamp_err <= 1'b1;
      end
    end else if (accept) begin
      if (state == ST_DATA && !last_byte) idx <= idx + 3'd1;
`ifdef UNLOADER_CHECKSUM_EN
      // Checksum covers header and data bytes only.
      if (state == ST_HDR_R || state == ST_HDR_C || state == ST_DATA)
        csum <= csum ^ stream.data_out;
`endif
    end
  end

endmodule

// File: tb/tb_result_unloader.sv
// Self-checking bench for result_unloader: table of frames checked through a byte
// scoreboard, plus hand-written reset, mid-frame res_valid and end-of-frame cases.
module tb_result_unloader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] res_mat = '0;
  logic [3:0]  rows = '0;
  logic [3:0]  cols = '0;
  logic        res_valid = 1'b0;
  logic        busy;
  logic        clamp_err;

  result_unloader_if u_if ();

  result_unloader #(.ELEM_W(16), .MAX_ELEMS(4)) dut (
    .CLK(clk), .RST(rst), .res_mat(res_mat), .rows(rows), .cols(cols),
    .res_valid(res_valid), .busy(busy), .clamp_err(clamp_err), .stream(u_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic [1:0] c; } byte_t;
  typedef struct {
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [63:0] mat;
    int          mode;
    logic        exp_clamp;
    int          exp_n;
  } vec_t;

  byte_t sbq[$];
  vec_t  vecs[8];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    data_cnt = 0;
  int    end_cnt = 0;
  int    mode = 0;
  int    rc = 0;
  bit    stall_seen = 0;
  logic [7:0] stall_d;
  logic [1:0] stall_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready driver: mode 0 always ready, mode 1 pattern 1,0,0,1, mode 2 random.
  initial begin
    u_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rc++;
      case (mode)
        1: case (rc % 4)
             0, 3:    u_if.out_ready = 1'b1;
             default: u_if.out_ready = 1'b0;
           endcase
        2: u_if.out_ready = 1'($urandom_range(0, 1));
        default: u_if.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares accepted bytes against the scoreboard, checks stall stability.
  initial begin
    byte_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_seen = 0;
      end else begin
        if (stall_seen && u_if.out_valid) begin
          chk("stall_data", u_if.data_out, stall_d);
          chk("stall_ctrl", u_if.ctrl_out, stall_c);
        end
`ifndef UNLOADER_CHECKSUM_EN
        if (u_if.out_valid && u_if.ctrl_out == 2'd3) chk("no_csum_ctrl", u_if.ctrl_out, 2'd0);
`endif
        if (u_if.out_valid && u_if.out_ready) begin
          stall_seen = 0;
          if (u_if.ctrl_out == 2'd0) data_cnt++;
          if (u_if.ctrl_out == 2'd2) end_cnt++;
          if (sbq.size() == 0) begin
            chk("unexpected_byte", {u_if.data_out, u_if.ctrl_out}, 10'h3ff);
          end else begin
            e = sbq.pop_front();
            chk("byte", {u_if.data_out, u_if.ctrl_out}, {e.d, e.c});
          end
        end else if (u_if.out_valid) begin
          stall_seen = 1;
          stall_d    = u_if.data_out;
          stall_c    = u_if.ctrl_out;
        end else begin
          stall_seen = 0;
        end
      end
    end
  end

  task automatic push_frame(input logic [3:0] r, input logic [3:0] c, input logic [63:0] m, input int n);
    logic [7:0]  cs;
    logic [63:0] sh;
    byte_t       b;
    cs = {4'b0, r} ^ {4'b0, c};
    b.d = {4'b0, r}; b.c = 2'd1; sbq.push_back(b);
    b.d = {4'b0, c}; b.c = 2'd1; sbq.push_back(b);
    for (int i = 0; i < 2 * n; i++) begin
      sh  = m >> (56 - 8 * i);
      b.d = sh[7:0];
      b.c = 2'd0;
      cs  = cs ^ b.d;
      sbq.push_back(b);
    end
`ifdef UNLOADER_CHECKSUM_EN
    b.d = cs; b.c = 2'd3; sbq.push_back(b);
`endif
    b.d = 8'h00; b.c = 2'd2; sbq.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", u_if.out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_clamp", clamp_err, 1'b0);
    chk("rst_data_ctrl", {u_if.data_out, u_if.ctrl_out}, 10'h0);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
  endtask

  task automatic start_frame(input logic [3:0] r, input logic [3:0] c, input logic [63:0] m);
    @(negedge clk);
    rows = r; cols = c; res_mat = m; res_valid = 1'b1;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    chk("latency_valid", u_if.out_valid, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int ends0;
    int k;
    vecs[0] = '{4'd2,  4'd2,  64'h0001_0002_0003_0004, 0, 1'b0, 4};
    vecs[1] = '{4'd2,  4'd2,  64'h0001_0002_0003_0004, 1, 1'b0, 4};
    vecs[2] = '{4'd3,  4'd2,  64'h1122_3344_5566_7788, 0, 1'b1, 4};
    vecs[3] = '{4'd0,  4'd4,  64'hdead_beef_cafe_f00d, 1, 1'b0, 0};
    vecs[4] = '{4'd1,  4'd1,  64'habcd_1234_5678_9abc, 2, 1'b0, 1};
    vecs[5] = '{4'd15, 4'd15, 64'h8001_7f02_00ff_a55a, 2, 1'b1, 4};
    vecs[6] = '{4'd1,  4'd4,  64'h0102_0304_0506_0708, 1, 1'b0, 4};
    vecs[7] = '{4'd1,  4'd3,  64'hf0e1_d2c3_b4a5_9687, 2, 1'b0, 3};

    for (int v = 0; v < 8; v++) begin
      do_reset();
      mode = vecs[v].mode;
      data_cnt = 0;
      ends0 = end_cnt;
      push_frame(vecs[v].rows, vecs[v].cols, vecs[v].mat, vecs[v].exp_n);
      start_frame(vecs[v].rows, vecs[v].cols, vecs[v].mat);
      wait_idle();
      chk("clamp_err", clamp_err, vecs[v].exp_clamp);
      chk("data_bytes", data_cnt, 2 * vecs[v].exp_n);
      chk("sb_empty", sbq.size(), 0);
      chk("end_seen", end_cnt - ends0, 1);
      chk("valid_after_end", u_if.out_valid, 1'b0);
    end

    // Reset while presenting data byte 3: no END, then a clean frame.
    do_reset();
    mode = 0;
    data_cnt = 0;
    ends0 = end_cnt;
    push_frame(4'd2, 4'd2, 64'h0001_0002_0003_0004, 4);
    start_frame(4'd2, 4'd2, 64'h0001_0002_0003_0004);
    k = 0;
    while (k < 50) begin
      @(posedge clk);
      #2;
      if (data_cnt == 3) break;
      k++;
    end
    chk("reach_byte3", data_cnt, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_valid", u_if.out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_end", end_cnt - ends0, 0);
    data_cnt = 0;
    push_frame(4'd2, 4'd2, 64'h0a0b_0c0d_0e0f_1011, 4);
    start_frame(4'd2, 4'd2, 64'h0a0b_0c0d_0e0f_1011);
    wait_idle();
    chk("after_abort_sb", sbq.size(), 0);
    chk("after_abort_data", data_cnt, 8);

    // res_valid with different data mid-frame must be ignored.
    do_reset();
    mode = 1;
    data_cnt = 0;
    push_frame(4'd2, 4'd2, 64'h0001_0002_0003_0004, 4);
    start_frame(4'd2, 4'd2, 64'h0001_0002_0003_0004);
    repeat (5) @(negedge clk);
    rows = 4'd3; cols = 4'd2; res_mat = 64'hffff_eeee_dddd_cccc; res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    wait_idle();
    chk("midframe_sb", sbq.size(), 0);
    chk("midframe_clamp", clamp_err, 1'b0);
    repeat (4) @(negedge clk);
    chk("midframe_stays_idle", busy, 1'b0);

    // res_valid in the END acceptance cycle must be ignored.
    mode = 0;
    push_frame(4'd1, 4'd1, 64'h5a5a_0000_0000_0000, 1);
    start_frame(4'd1, 4'd1, 64'h5a5a_0000_0000_0000);
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (u_if.out_valid && u_if.ctrl_out == 2'd2 && u_if.out_ready) break;
      k++;
    end
    res_valid = 1'b1;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    chk("end_rv_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("end_rv_idle", busy, 1'b0);
    chk("end_rv_sb", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
